matmul_tile_engine: RTL and testbench
=====================================

Name: matmul_tile_engine

Overview:
- Parametrised output-stationary matrix-multiply engine, C[M×N] = (A + input_offset) · B, for an ARRAY_DIM×ARRAY_DIM systolic array.
- Reads tiled A and B words from single-port SRAMs and applies input skew internally.
- Accumulates K products per tile, then writes each output row of the tile to C SRAM.
- Sits between the host command interface and the three buffer SRAMs; supersedes the fixed 4×4 engine.

Parameters:
ARRAY_DIM, 4, PE rows/columns; elements per A/B word; lanes per C word
DATA_W, 8, signed A/B element width
ACC_W, 32, signed accumulator width per PE
OFFSET_W, 9, signed input_offset width
DIM_W, 8, width of K/M/N
ADDR_W, 12, SRAM address width

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  command strobe; sampled only in IDLE
input_offset  in  OFFSET_W  signed offset added to every A element
k_dim  in  DIM_W  reduction length K
m_dim  in  DIM_W  rows of A/C
n_dim  in  DIM_W  columns of B/C
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the last C row has been written
a_rd_en  out  1  A read strobe
a_addr  out  ADDR_W  A address
a_rdata  in  ARRAY_DIM*DATA_W  A word; lane i = row (mt*ARRAY_DIM+i) of column k
b_rd_en  out  1  B read strobe
b_addr  out  ADDR_W  B address
b_rdata  in  ARRAY_DIM*DATA_W  B word; lane j = column (nt*ARRAY_DIM+j) of row k
c_wr_en  out  1  C write strobe
c_addr  out  ADDR_W  C address
c_wdata  out  ARRAY_DIM*ACC_W  C word; lane j = column j of the tile

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
- Reset outputs: all outputs 0; state IDLE; counters and accumulators cleared.
- Reset mid-operation aborts the job with no further SRAM access.
- Command capture: on start in IDLE, latch K/M/N and input_offset.
- Tile counts: MT = ceil(M/ARRAY_DIM), NT = ceil(N/ARRAY_DIM).
- Zero dimension: if K, M or N is 0, go directly to DONE; no reads or writes.
- start while busy is ignored.
- Addressing: A word for (mt,k) = mt*K+k; B word for (nt,k) = nt*K+k.
- Tile order: mt outer, nt inner.
- C addressing: c_addr starts at 0 and increments by 1 per written row.
- SRAM read latency is 1 cycle.
- Skew: lane i of A and lane j of B are delayed by i cycles before entering the array.
- Skew feed: while not in LOAD, zeros are fed into the skew chain.
- PE operation: acc += (sext(a)+offset) * sext(b).
- Arithmetic: products are sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W.
- FSM states: IDLE, LOAD, DRAIN, WRITE, DONE.
  - IDLE→LOAD on accepted start with nonzero dimensions.
  - LOAD: issue K consecutive reads (a_rd_en=b_rd_en=1); →DRAIN after the K-th read.
  - DRAIN: exactly 2*ARRAY_DIM cycles, no reads; →WRITE.
  - WRITE: one row per cycle for R rows, R = min(ARRAY_DIM, M - mt*ARRAY_DIM).
  - Row r write: c_wdata = row r of the accumulators.
  - Column masking: lanes j ≥ N - nt*ARRAY_DIM are forced to 0.
  - Accumulators are cleared on the cycle after the last WRITE row.
  - After WRITE: →LOAD for the next tile, or →DONE after tile (MT-1, NT-1).
  - DONE: done=1 for one cycle, busy=1; →IDLE.
- Total C rows written = M*NT.
- Boundary: K=1 is legal, giving LOAD of 1 cycle.
- Boundary: M or N not a multiple of ARRAY_DIM uses partial rows or masked lanes.
- Boundary: K*max(MT,NT) must fit ADDR_W; beyond that is undefined.
- Back-to-back: start may be asserted on the cycle after done; it is accepted in IDLE.

Optional Feature:
- MATMUL_PERF_CNT_EN defined: adds output port cycle_count (32 bits).
  - Cleared on accepted start.
  - Increments every busy cycle.
  - Holds after done until the next start; resets to 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package matmul_pkg holds:
  - FSM state enum (IDLE/LOAD/DRAIN/WRITE/DONE).
  - DRAIN_CYCLES = 2*ARRAY_DIM.
  - Lane slicing helper functions.
- Sub-module mac_pe: one PE.
  - Operand pass-through registers (A right, B down).
  - Accumulator with synchronous clear.
- The engine generates the ARRAY_DIM² PE grid and the per-lane skew delay lines inline.

Test Plan:
- Identity B (ARRAY_DIM=4): K=M=N=4, offset=0, A=1..16 → C rows equal A rows (sign-extended); 4 writes at c_addr 0..3; done one cycle after the last write.
- Partial tiles: K=3, M=5, N=6, random signed data → 10 C writes (M*NT=5*2) matching the golden model; lanes ≥2 of nt=1 words are 0; mt=1 tiles write 1 row each.
- Offset: A all -128, B all 1, offset=128, K=8 → all C lanes 0; with offset=127 → all -8.
- Start while busy: pulse start mid-LOAD with different dims → ignored; results match the first command only.
- Reset mid-DRAIN: assert rst_n=0 one cycle → next cycle busy=0 and all strobes 0; a fresh job then produces correct results (no stale accumulation).
- Zero dimension: K=0, M=4, N=4 → no rd/wr strobes; done pulses within 2 cycles of start.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the tiled output-stationary matrix-multiply engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Cycles needed after the last read before the far-corner PE holds its final sum.
    function automatic int drain_cycles(input int array_dim);
        return 2 * array_dim;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element: forwards A to the right and B downward, accumulates (a+offset)*b.
module mac_pe
    import matmul_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int OFFSET_W = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       acc_clr,
    input  logic signed [OFFSET_W-1:0] offset,
    input  logic signed [DATA_W-1:0]   a_in,
    input  logic signed [DATA_W-1:0]   b_in,
    output logic signed [DATA_W-1:0]   a_out,
    output logic signed [DATA_W-1:0]   b_out,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int SUM_W  = ((DATA_W > OFFSET_W) ? DATA_W : OFFSET_W) + 1;
    localparam int PROD_W = SUM_W + DATA_W;

    logic signed [SUM_W-1:0]  a_sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] a_d, a_q, b_d, b_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        a_sum = SUM_W'(a_in) + SUM_W'(offset);
        prod  = PROD_W'(a_sum) * PROD_W'(b_in);
        acc_d = acc_clr ? '0 : acc_q + ACC_W'(prod);
        a_d   = a_in;
        b_d   = b_in;
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/matmul_tile_engine.sv
// Tiled output-stationary C = (A + offset) * B engine driving A/B/C SRAMs.
// Define MATMUL_PERF_CNT_EN to add the cycle_count busy-cycle counter port.
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter int ARRAY_DIM = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int OFFSET_W  = 9,
    parameter int DIM_W     = 8,
    parameter int ADDR_W    = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [OFFSET_W-1:0]    input_offset,
    input  logic [DIM_W-1:0]              k_dim,
    input  logic [DIM_W-1:0]              m_dim,
    input  logic [DIM_W-1:0]              n_dim,
    output logic                          busy,
    output logic                          done,
    output logic                          a_rd_en,
    output logic [ADDR_W-1:0]             a_addr,
    input  logic [ARRAY_DIM*DATA_W-1:0]   a_rdata,
    output logic                          b_rd_en,
    output logic [ADDR_W-1:0]             b_addr,
    input  logic [ARRAY_DIM*DATA_W-1:0]   b_rdata,
    output logic                          c_wr_en,
    output logic [ADDR_W-1:0]             c_addr,
    output logic [ARRAY_DIM*ACC_W-1:0]    c_wdata
`ifdef MATMUL_PERF_CNT_EN
    ,
    output logic [31:0]                   cycle_count
`endif
);

    localparam int                 DRAIN_CYCLES = drain_cycles(ARRAY_DIM);
    localparam int                 DC_W         = $clog2(DRAIN_CYCLES);
    localparam logic [DIM_W-1:0]   DIM_D        = DIM_W'(ARRAY_DIM);
    localparam logic [DIM_W-1:0]   ONE_D        = DIM_W'(1);
    localparam logic [ADDR_W-1:0]  ONE_A        = ADDR_W'(1);

    state_e                      state_q;
    logic                        rd_en_q, rd_vld_d, rd_vld_q;
    logic                        c_wr_en_q, busy_q, done_q;
    logic [ADDR_W-1:0]           a_addr_q, b_addr_q, a_base_q, b_base_q, c_addr_q;
    logic [ARRAY_DIM*ACC_W-1:0]  c_wdata_q;
    logic [DIM_W-1:0]            k_dim_q, n_dim_q, m_left_q, n_left_q, k_cnt_q, row_q;
    logic [DC_W-1:0]             drain_cnt_q;
    logic signed [OFFSET_W-1:0]  offset_q;

    logic [ADDR_W-1:0]           k_step;
    logic [DIM_W-1:0]            last_row, wr_sel;
    logic                        acc_clr;
    logic [ARRAY_DIM*ACC_W-1:0]  row_word;

    logic signed [DATA_W-1:0] a_h [ARRAY_DIM][ARRAY_DIM+1];
    logic signed [DATA_W-1:0] b_v [ARRAY_DIM+1][ARRAY_DIM];
    logic signed [ACC_W-1:0]  acc [ARRAY_DIM][ARRAY_DIM];

    // Read data is valid the cycle after a read strobe; outside that window zeros flush the array.
    assign rd_vld_d = rd_en_q;

    always_ff @(posedge clk) begin
        if (!rst_n) rd_vld_q <= 1'b0;
        else        rd_vld_q <= rd_vld_d;
    end

    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_skew
        logic signed [DATA_W-1:0] a_feed, b_feed;
        assign a_feed = rd_vld_q ? a_rdata[lane_lo(i, DATA_W) +: DATA_W] : '0;
        assign b_feed = rd_vld_q ? b_rdata[lane_lo(i, DATA_W) +: DATA_W] : '0;

        if (i == 0) begin : g_direct
            assign a_h[i][0] = a_feed;
            assign b_v[0][i] = b_feed;
        end else begin : g_delay
            logic signed [DATA_W-1:0] a_sk_d [i];
            logic signed [DATA_W-1:0] a_sk_q [i];
            logic signed [DATA_W-1:0] b_sk_d [i];
            logic signed [DATA_W-1:0] b_sk_q [i];

            always_comb begin
                a_sk_d[0] = a_feed;
                b_sk_d[0] = b_feed;
                for (int s = 1; s < i; s++) begin
                    a_sk_d[s] = a_sk_q[s-1];
                    b_sk_d[s] = b_sk_q[s-1];
                end
            end

            // NOTE: skew stages are reset so an aborted job leaves no operands in flight.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_sk_q[s] <= '0;
                        b_sk_q[s] <= '0;
                    end
                end else begin
                    a_sk_q <= a_sk_d;
                    b_sk_q <= b_sk_d;
                end
            end

            assign a_h[i][0] = a_sk_q[i-1];
            assign b_v[0][i] = b_sk_q[i-1];
        end
    end

    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
            mac_pe #(
                .DATA_W  (DATA_W),
                .ACC_W   (ACC_W),
                .OFFSET_W(OFFSET_W)
            ) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .acc_clr(acc_clr),
                .offset (offset_q),
                .a_in   (a_h[r][c]),
                .b_in   (b_v[r][c]),
                .a_out  (a_h[r][c+1]),
                .b_out  (b_v[r+1][c]),
                .acc    (acc[r][c])
            );
        end
    end

    always_comb begin
        k_step   = ADDR_W'(k_dim_q);
        last_row = (m_left_q < DIM_D) ? m_left_q - ONE_D : DIM_D - ONE_D;
        acc_clr  = (state_q == ST_WRITE) && (row_q == last_row);
        // Row to present next: row 0 when leaving DRAIN, otherwise the following row.
        wr_sel   = (state_q == ST_DRAIN) ? '0 : row_q + ONE_D;
        row_word = '0;
        for (int r = 0; r < ARRAY_DIM; r++) begin
            for (int c = 0; c < ARRAY_DIM; c++) begin
                if (DIM_W'(r) == wr_sel && DIM_W'(c) < n_left_q)
                    row_word[lane_lo(c, ACC_W) +: ACC_W] = acc[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_en_q     <= 1'b0;
            c_wr_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_addr_q    <= '0;
            c_wdata_q   <= '0;
            k_dim_q     <= '0;
            n_dim_q     <= '0;
            m_left_q    <= '0;
            n_left_q    <= '0;
            k_cnt_q     <= '0;
            row_q       <= '0;
            drain_cnt_q <= '0;
            offset_q    <= '0;
        end else begin
            rd_en_q   <= 1'b0;
            c_wr_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    k_dim_q  <= k_dim;
                    n_dim_q  <= n_dim;
                    m_left_q <= m_dim;
                    n_left_q <= n_dim;
                    offset_q <= input_offset;
                    a_base_q <= '0;
                    b_base_q <= '0;
                    a_addr_q <= '0;
                    b_addr_q <= '0;
                    c_addr_q <= '0;
                    k_cnt_q  <= '0;
                    busy_q   <= 1'b1;
                    if (k_dim == '0 || m_dim == '0 || n_dim == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_LOAD;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_LOAD: if (k_cnt_q == k_dim_q - ONE_D) begin
                    state_q     <= ST_DRAIN;
                    drain_cnt_q <= '0;
                end else begin
                    k_cnt_q  <= k_cnt_q + ONE_D;
                    a_addr_q <= a_addr_q + ONE_A;
                    b_addr_q <= b_addr_q + ONE_A;
                    rd_en_q  <= 1'b1;
                end
                ST_DRAIN: if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
                    state_q   <= ST_WRITE;
                    row_q     <= '0;
                    c_wr_en_q <= 1'b1;
                    c_wdata_q <= row_word;
                end else begin
                    drain_cnt_q <= drain_cnt_q + DC_W'(1);
                end
                ST_WRITE: begin
                    c_addr_q <= c_addr_q + ONE_A;
                    if (row_q == last_row) begin
                        k_cnt_q <= '0;
                        if (n_left_q <= DIM_D) begin
                            if (m_left_q <= DIM_D) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= ST_LOAD;
                                rd_en_q  <= 1'b1;
                                m_left_q <= m_left_q - DIM_D;
                                n_left_q <= n_dim_q;
                                a_base_q <= a_base_q + k_step;
                                a_addr_q <= a_base_q + k_step;
                                b_base_q <= '0;
                                b_addr_q <= '0;
                            end
                        end else begin
                            state_q  <= ST_LOAD;
                            rd_en_q  <= 1'b1;
                            n_left_q <= n_left_q - DIM_D;
                            b_base_q <= b_base_q + k_step;
                            b_addr_q <= b_base_q + k_step;
                            a_addr_q <= a_base_q;
                        end
                    end else begin
                        row_q     <= row_q + ONE_D;
                        c_wr_en_q <= 1'b1;
                        c_wdata_q <= row_word;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign a_rd_en = rd_en_q;
    assign b_rd_en = rd_en_q;
    assign a_addr  = a_addr_q;
    assign b_addr  = b_addr_q;
    assign c_wr_en = c_wr_en_q;
    assign c_addr  = c_addr_q;
    assign c_wdata = c_wdata_q;

`ifdef MATMUL_PERF_CNT_EN
    logic [31:0] cycle_count_d, cycle_count_q;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (state_q == ST_IDLE && start) cycle_count_d = '0;
        else if (busy_q)                 cycle_count_d = cycle_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cycle_count_q <= '0;
        else        cycle_count_q <= cycle_count_d;
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Scoreboard bench for matmul_tile_engine: SRAM models, expected-write queue, negedge monitor.
module tb_matmul_tile_engine;

    localparam int D    = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int OW   = 9;
    localparam int DIMW = 8;
    localparam int ADW  = 12;
    localparam int CW   = D * AW;

    typedef struct {
        logic [ADW-1:0] addr;
        logic [CW-1:0]  data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic signed [OW-1:0]  input_offset = '0;
    logic [DIMW-1:0]       k_dim = '0, m_dim = '0, n_dim = '0;
    logic                  busy, done;
    logic                  a_rd_en, b_rd_en, c_wr_en;
    logic [ADW-1:0]        a_addr, b_addr, c_addr;
    logic [D*DW-1:0]       a_rdata = '0, b_rdata = '0;
    logic [CW-1:0]         c_wdata;
`ifdef MATMUL_PERF_CNT_EN
    logic [31:0]           cycle_count;
`endif

    always #5 clk = ~clk;

    matmul_tile_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .input_offset(input_offset),
        .k_dim       (k_dim),
        .m_dim       (m_dim),
        .n_dim       (n_dim),
        .busy        (busy),
        .done        (done),
        .a_rd_en     (a_rd_en),
        .a_addr      (a_addr),
        .a_rdata     (a_rdata),
        .b_rd_en     (b_rd_en),
        .b_addr      (b_addr),
        .b_rdata     (b_rdata),
        .c_wr_en     (c_wr_en),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata)
`ifdef MATMUL_PERF_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    logic [D*DW-1:0] a_mem [4096];
    logic [D*DW-1:0] b_mem [4096];
    int              mat_a [16][16];
    int              mat_b [16][16];
    exp_t            exp_q [$];

    int n_vec = 0, n_err = 0;
    int wr_count = 0, rd_count = 0, cyc = 0, last_wr_cyc = 0;
    bit check_gap = 1'b0;

    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= a_mem[a_addr];
        if (b_rd_en) b_rdata <= b_mem[b_addr];
    end

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per C write; checks done follows the last write by one cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (a_rd_en || b_rd_en) rd_count++;
            if (c_wr_en) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0d data %h with empty queue", c_addr, c_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("c_addr", CW'(c_addr), CW'(e.addr));
                    check("c_wdata", c_wdata, e.data);
                end
            end
            if (done && check_gap) check("done_after_last_write", CW'(cyc - last_wr_cyc), CW'(1));
        end
    end

    function automatic logic [AW-1:0] dot(input int row, input int col, input int k_n, input int off);
        int acc = 0;
        for (int k = 0; k < k_n; k++) acc += (mat_a[row][k] + off) * mat_b[k][col];
        return AW'(acc);
    endfunction

    task automatic load_mems(input int k_n, input int m_n, input int n_n);
        int mt_n = (m_n + D - 1) / D;
        int nt_n = (n_n + D - 1) / D;
        for (int a = 0; a < 256; a++) begin
            a_mem[a] = '0;
            b_mem[a] = '0;
        end
        for (int t = 0; t < mt_n; t++)
            for (int k = 0; k < k_n; k++)
                for (int i = 0; i < D; i++)
                    if (t * D + i < m_n) a_mem[t*k_n+k][i*DW +: DW] = DW'(mat_a[t*D+i][k]);
        for (int t = 0; t < nt_n; t++)
            for (int k = 0; k < k_n; k++)
                for (int j = 0; j < D; j++)
                    if (t * D + j < n_n) b_mem[t*k_n+k][j*DW +: DW] = DW'(mat_b[k][t*D+j]);
    endtask

    task automatic push_model(input int k_n, input int m_n, input int n_n, input int off);
        exp_t e;
        int   c = 0;
        for (int mt = 0; mt < (m_n + D - 1) / D; mt++)
            for (int nt = 0; nt < (n_n + D - 1) / D; nt++)
                for (int r = 0; r < D && mt * D + r < m_n; r++) begin
                    e.addr = ADW'(c);
                    e.data = '0;
                    for (int j = 0; j < D; j++)
                        if (nt * D + j < n_n) e.data[j*AW +: AW] = dot(mt * D + r, nt * D + j, k_n, off);
                    exp_q.push_back(e);
                    c++;
                end
    endtask

    task automatic start_job(input int k_n, input int m_n, input int n_n, input int off);
        for (int w = 0; w < 200 && busy; w++) @(negedge clk);
        wr_count     = 0;
        rd_count     = 0;
        k_dim        = DIMW'(k_n);
        m_dim        = DIMW'(m_n);
        n_dim        = DIMW'(n_n);
        input_offset = OW'(off);
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(input string name, output int waited);
        waited = 1;
        while (!done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_done_seen"}, CW'(done), CW'(1));
    endtask

    task automatic finish_job(input string name, input int writes);
        check({name, "_write_count"}, CW'(wr_count), CW'(writes));
        check({name, "_queue_empty"}, CW'(exp_q.size()), CW'(0));
    endtask

    initial begin
        exp_t e;
        int   waited;

        repeat (3) @(negedge clk);
        check("reset_strobes", CW'({busy, done, a_rd_en, b_rd_en, c_wr_en}), CW'(0));
        check("reset_addrs", CW'({a_addr, b_addr, c_addr}), CW'(0));
        check("reset_wdata", c_wdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity B: C rows equal A rows.
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                mat_a[r][k] = r * 4 + k + 1;
                mat_b[r][k] = (r == k) ? 1 : 0;
            end
        load_mems(4, 4, 4);
        for (int r = 0; r < 4; r++) begin
            e.addr = ADW'(r);
            for (int j = 0; j < D; j++) e.data[j*AW +: AW] = AW'(r * 4 + j + 1);
            exp_q.push_back(e);
        end
        check_gap = 1'b1;
        start_job(4, 4, 4, 0);
        wait_done("identity", waited);
        finish_job("identity", 4);

        // Partial tiles with signed data, started back-to-back after done.
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) begin
                mat_a[r][k] = int'($urandom_range(0, 255)) - 128;
                mat_b[r][k] = int'($urandom_range(0, 255)) - 128;
            end
        load_mems(3, 5, 6);
        push_model(3, 5, 6, 0);
        start_job(3, 5, 6, 0);
        wait_done("partial", waited);
        finish_job("partial", 10);

        // Offset cancels A = -128 exactly; offset 127 leaves -1 per product.
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) begin
                mat_a[r][k] = -128;
                mat_b[r][k] = 1;
            end
        load_mems(8, 4, 4);
        for (int r = 0; r < 4; r++) begin
            e.addr = ADW'(r);
            e.data = '0;
            exp_q.push_back(e);
        end
        start_job(8, 4, 4, 128);
        wait_done("offset128", waited);
        finish_job("offset128", 4);
        for (int r = 0; r < 4; r++) begin
            e.addr = ADW'(r);
            for (int j = 0; j < D; j++) e.data[j*AW +: AW] = 32'hFFFF_FFF8;
            exp_q.push_back(e);
        end
        start_job(8, 4, 4, 127);
        wait_done("offset127", waited);
        finish_job("offset127", 4);

        // Second start mid-LOAD with different dims must be ignored.
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) begin
                mat_a[r][k] = int'($urandom_range(0, 255)) - 128;
                mat_b[r][k] = int'($urandom_range(0, 255)) - 128;
            end
        load_mems(4, 4, 4);
        push_model(4, 4, 4, -3);
        start_job(4, 4, 4, -3);
        @(negedge clk);
        k_dim        = 8'd2;
        m_dim        = 8'd8;
        n_dim        = 8'd8;
        input_offset = 9'sd5;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done("start_busy", waited);
        finish_job("start_busy", 4);

        // Reset in DRAIN aborts the job; a fresh job afterwards is clean.
        check_gap = 1'b0;
        start_job(4, 4, 4, 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_strobes", CW'({busy, done, a_rd_en, b_rd_en, c_wr_en}), CW'(0));
        repeat (20) @(negedge clk);
        check("abort_no_writes", CW'(wr_count), CW'(0));
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < 16; c++) mat_b[k][c] = int'($urandom_range(0, 255)) - 128;
        load_mems(4, 4, 4);
        push_model(4, 4, 4, 0);
        check_gap = 1'b1;
        start_job(4, 4, 4, 0);
        wait_done("after_reset", waited);
        finish_job("after_reset", 4);

        // Zero K: no SRAM traffic, done within two cycles of start.
        check_gap = 1'b0;
        start_job(0, 4, 4, 0);
        wait_done("zero_k", waited);
        check("zero_k_latency_ok", CW'(waited <= 2), CW'(1));
        repeat (3) @(negedge clk);
        check("zero_k_reads", CW'(rd_count), CW'(0));
        finish_job("zero_k", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
